// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: target FSM states, transfer direction and byte width.
// Used by both the SCCB target and the SCCB initiator.
package sccb_pkg;

  localparam int   SCCB_BYTE_W = 8;
  localparam logic SCCB_WR     = 1'b0;
  localparam logic SCCB_RD     = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB_HI,
    ST_HI_ACK,
    ST_SUB_LO,
    ST_LO_ACK,
    ST_WDATA,
    ST_WD_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_IGNORE
  } sccb_tgt_state_t;

endpackage

// File: rtl/sccb_in_filter.sv
// Two-flop synchronizer plus glitch filter for one bus line.
// Produces a clean level and single-cycle rise/fall strobes aligned with it.
module sccb_in_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic sysclk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments only; the sync and
  // level flops reset to 1 so an idle (pulled-up) bus is not seen as an edge.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_s2;
        r_rise  <= r_s2;
        r_fall  <= ~r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder: decodes START/STOP, device ID, 16-bit sub-address and data
// phases, and maps register accesses onto a parallel write/read-request port.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID     = 7'h36,
  parameter int         FILTER_LEN = 3
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   sda_oe,
  output logic                   wr_valid,
  output logic [15:0]            wr_addr,
  output logic [SCCB_BYTE_W-1:0] wr_data,
  output logic                   rd_req,
  output logic [15:0]            rd_addr,
  input  logic [SCCB_BYTE_W-1:0] rd_data,
  output logic                   busy
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  sccb_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .sysclk (sysclk),
    .rst    (rst),
    .i_raw  (scl_i),
    .o_level(w_scl_lvl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  sccb_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .sysclk (sysclk),
    .rst    (rst),
    .i_raw  (sda_i),
    .o_level(w_sda_lvl),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  sccb_tgt_state_t        r_state;
  logic [6:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [15:0]            r_ptr;
  logic                   r_rw;
  logic                   r_ack_on;
  logic [SCCB_BYTE_W-1:0] r_tx;
  logic                   r_tx_drv;
  logic                   r_rd_req_d;
  logic                   r_sda_oe;
  logic                   r_wr_valid;
  logic [15:0]            r_wr_addr;
  logic [SCCB_BYTE_W-1:0] r_wr_data;
  logic                   r_rd_req;
  logic [15:0]            r_rd_addr;
  logic                   r_busy;

  logic                   w_start, w_stop, w_last_bit;
  logic [SCCB_BYTE_W-1:0] w_byte;

  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  assign w_byte     = {r_shift, w_sda_lvl};
  assign w_last_bit = (r_bit_cnt == 3'd7);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ptr      <= '0;
      r_rw       <= SCCB_WR;
      r_ack_on   <= 1'b0;
      r_tx       <= '0;
      r_tx_drv   <= 1'b0;
      r_rd_req_d <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_req_d <= r_rd_req;
      if (w_start) begin
        r_state   <= ST_ID;
        r_bit_cnt <= '0;
        r_ack_on  <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ID, ST_SUB_HI, ST_SUB_LO, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ack_on <= 1'b0;
                case (r_state)
                  ST_ID: begin
                    if (w_byte[7:1] == DEV_ID) begin
                      r_rw    <= w_byte[0];
                      r_state <= ST_ID_ACK;
                    end else begin
                      r_state <= ST_IGNORE;
                    end
                  end
                  ST_SUB_HI: begin
                    r_ptr[15:8] <= w_byte;
                    r_state     <= ST_HI_ACK;
                  end
                  ST_SUB_LO: begin
                    r_ptr[7:0] <= w_byte;
                    r_state    <= ST_LO_ACK;
                  end
                  default: begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_ptr;
                    r_wr_data  <= w_byte;
                    r_ptr      <= r_ptr + 16'd1;
                    r_state    <= ST_WD_ACK;
                  end
                endcase
              end
            end
          end
          // ACK is held low from the fall after bit 8 until the next fall.
          ST_ID_ACK, ST_HI_ACK, ST_LO_ACK, ST_WD_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_ack_on <= 1'b1;
                r_sda_oe <= 1'b1;
              end else begin
                r_ack_on  <= 1'b0;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                case (r_state)
                  ST_ID_ACK: begin
                    if (r_rw == SCCB_RD) begin
                      r_state   <= ST_RDATA;
                      r_rd_req  <= 1'b1;
                      r_rd_addr <= r_ptr;
                      r_tx_drv  <= 1'b0;
                    end else begin
                      r_state <= ST_SUB_HI;
                    end
                  end
                  ST_HI_ACK: r_state <= ST_SUB_LO;
                  default:   r_state <= ST_WDATA;
                endcase
              end
            end
          end
          // First bit goes out on latch if SCL is already low, else on the next fall.
          ST_RDATA: begin
            if (r_rd_req_d) begin
              r_tx      <= rd_data;
              r_bit_cnt <= '0;
              if (!w_scl_lvl) begin
                r_sda_oe <= ~rd_data[7];
                r_tx_drv <= 1'b1;
              end
            end else if (w_scl_fall) begin
              if (!r_tx_drv) begin
                r_sda_oe <= ~r_tx[7];
                r_tx_drv <= 1'b1;
              end else if (w_last_bit) begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_RD_ACK;
              end else begin
                r_sda_oe  <= ~r_tx[6];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda_lvl) begin
                r_ptr     <= r_ptr + 16'd1;
                r_rd_req  <= 1'b1;
                r_rd_addr <= r_ptr + 16'd1;
                r_tx_drv  <= 1'b0;
                r_state   <= ST_RDATA;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_req   = r_rd_req;
  assign rd_addr  = r_rd_addr;
  assign busy     = r_busy;

endmodule
